// File: rtl/mem_access_unit.sv
// Load/store initiator for a comb-read, posedge-write memory of W bytes; sub-word stores use read-modify-write.
// Latency: load and word store respond 2 cycles after accept, sub-word store 3; one request at a time, no response backpressure.
module mem_access_unit #(
    parameter int W      = 4,
    parameter int Addr_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [Addr_W-1:0] req_address,
    input  logic [8*W-1:0]    req_wdata,
    output logic              rsp_valid,
    output logic [8*W-1:0]    rsp_rdata,
    output logic [Addr_W-1:0] mem_address,
    output logic [8*W-1:0]    mem_write_data,
    output logic              mem_write_enable,
    input  logic [8*W-1:0]    mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              lat_write;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [Addr_W-1:0] lat_address;
    logic              ext_bit;
    logic [8*W-1:0]    load_fmt;
    logic [8*W-1:0]    merged;

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // word/reserved stores need no merge base, so they skip the read
                    next_state = (req_write && req_size[1]) ? WRITE : READ;
                end
            end
            READ: begin
                mem_address = lat_address;
                next_state  = lat_write ? WRITE : RESP;
            end
            WRITE: begin
                mem_address      = lat_address;
                mem_write_enable = 1'b1;
                next_state       = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ext_bit  = lat_signed && ((lat_size == 2'd0) ? mem_read_data[7] : mem_read_data[15]);
        load_fmt = mem_read_data;
        if (lat_size == 2'd0) begin
            for (int i = 8; i < 8*W; i++) load_fmt[i] = ext_bit;
        end else if (lat_size == 2'd1) begin
            for (int i = 16; i < 8*W; i++) load_fmt[i] = ext_bit;
        end
    end

    // mem_write_data still holds the store data latched at accept while in READ
    always_comb begin
        merged = mem_read_data;
        merged[7:0] = mem_write_data[7:0];
        if (lat_size == 2'd1) begin
            merged[15:8] = mem_write_data[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_write      <= 1'b0;
            lat_size       <= 2'd0;
            lat_signed     <= 1'b0;
            lat_address    <= '0;
            mem_write_data <= '0;
            rsp_rdata      <= '0;
        end else begin
            if (accept) begin
                lat_write      <= req_write;
                lat_size       <= req_size;
                lat_signed     <= req_signed;
                lat_address    <= req_address;
                mem_write_data <= req_wdata;
            end
            if (state == READ) begin
                if (lat_write) begin
                    mem_write_data <= merged;
                end else begin
                    rsp_rdata <= load_fmt;
                end
            end
            if (state == WRITE) begin
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array memory (comb read, posedge write).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [7:0]  mem [0:255];
    int          total = 0;
    int          bad = 0;
    int          we_pulses = 0;
    logic [31:0] got;
    int          lat;

    always #5 clk = ~clk;

    mem_access_unit #(.W(4), .Addr_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) mem_read_data[8*i +: 8] = mem[8'(mem_address + 8'(i))];
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            for (int i = 0; i < 4; i++) mem[8'(mem_address + 8'(i))] <= mem_write_data[8*i +: 8];
            we_pulses <= we_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge; returns rdata and cycles from accept to rsp_valid.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int cycles);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_address = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cycles = 0;
        rd = 'x;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cycles = k;
                rd = rsp_rdata;
                break;
            end
        end
        if (cycles == 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout observed=none expected=rsp_valid within 10 cycles");
        end
    endtask

    initial begin
        int pulses;
        int first_k;
        int last_k;
        int gap_bad;
        logic [31:0] rsp_q [$];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_address = 8'h00; req_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_we", {31'd0, mem_write_enable}, 32'd0);
        check("rst_addr", {24'd0, mem_address}, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Word store interrupted by reset during its WRITE cycle
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_address = 8'h20; req_wdata = 32'hCAFEBABE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_we_before_rst", {31'd0, mem_write_enable}, 32'd1);
        check("mid_addr_before_rst", {24'd0, mem_address}, 32'h20);
        reset = 1'b1;
        #1;
        check("mid_we_after_rst", {31'd0, mem_write_enable}, 32'd0);
        check("mid_ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_mem_unchanged", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'd0);
        check("mid_no_write", we_pulses, 0);

        do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, got, lat);
        check("wst_rdata", got, 32'd0);
        check("wst_latency", lat, 2);
        check("wst_pulses", we_pulses, 1);
        check("mem10", {24'd0, mem[8'h10]}, 32'hEF);
        check("mem13", {24'd0, mem[8'h13]}, 32'hDE);

        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, got, lat);
        check("wld_10", got, 32'hDEADBEEF);
        check("wld_latency", lat, 2);
        @(negedge clk);
        check("rdata_held", rsp_rdata, 32'hDEADBEEF);

        do_req(1'b0, 2'd0, 1'b1, 8'h13, 32'h0, got, lat);
        check("bld_s_13", got, 32'hFFFFFFDE);
        check("bld_latency", lat, 2);
        @(negedge clk);
        do_req(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, got, lat);
        check("bld_u_13", got, 32'h000000DE);

        @(negedge clk);
        do_req(1'b1, 2'd0, 1'b0, 8'h11, 32'hAABBCC55, got, lat);
        check("bst_latency", lat, 3);
        check("bst_pulses", we_pulses, 2);
        check("bst_rdata", got, 32'd0);
        check("bst_mem14", {24'd0, mem[8'h14]}, 32'd0);
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, got, lat);
        check("wld_after_bst", got, 32'hDEAD55EF);

        @(negedge clk);
        do_req(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, got, lat);
        check("hld_s_12", got, 32'hFFFFDEAD);
        @(negedge clk);
        do_req(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, got, lat);
        check("hld_u_12", got, 32'h0000DEAD);
        @(negedge clk);
        do_req(1'b1, 2'd1, 1'b0, 8'h10, 32'h99991234, got, lat);
        check("hst_latency", lat, 3);
        check("hst_pulses", we_pulses, 3);
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, got, lat);
        check("wld_after_hst", got, 32'hDEAD1234);

        @(negedge clk);
        do_req(1'b0, 2'd3, 1'b0, 8'h10, 32'h0, got, lat);
        check("rsv_size_load", got, 32'hDEAD1234);

        // Three loads with req_valid held high: accepts every 3 cycles
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_address = 8'h10;
        pulses = 0; first_k = 0; last_k = 0; gap_bad = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                rsp_q.push_back(rsp_rdata);
                if (first_k == 0) first_k = k;
                else if (k - last_k != 3) gap_bad++;
                last_k = k;
            end
            if (k == 7) req_valid = 1'b0;
        end
        check("b2b_pulses", pulses, 3);
        check("b2b_first", first_k, 2);
        check("b2b_spacing", gap_bad, 0);
        for (int i = 0; i < rsp_q.size(); i++) check("b2b_rdata", rsp_q[i], 32'hDEAD1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
